irq_controller: RTL and testbench

Machine-level interrupt controller in front of the trap sequencer. It collects up to `N_SRC` external interrupt lines plus an optional machine timer. It prioritises them, presents a single registered `irq_req`/`irq_id` to the exception logic, and tracks one in-service interrupt from trap entry (`irq_ack`) to `mret` (`irq_complete`). Software configures it through a small word-addressed register port on the memory side.

---
 rtl/irq_controller.sv | 188 ++++++++++++++++++
 tb/tb_irq_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Machine-level interrupt controller: synchronises N_SRC external lines
// (edge or level per EDGE_MASK) plus an optional machine timer, picks the
// lowest pending+enabled id, and tracks one in-service interrupt from
// trap entry (ack) to mret (complete).
// Ports:
//   clk_i, rst_i (async, active-high)
//   src_i            raw interrupt lines
//   irq_req_o/_id_o  registered request and id
//   irq_ack_i        trap entry pulse
//   irq_complete_i   mret pulse
//   cfg_*            word-addressed register port (combinational read)
// Build option: define IRQ_CTRL_TIMER_EN to add MTIME/MTIMECMP and
// timer source id N_SRC; without it those registers read 0.
module irq_controller #(
    parameter int               N_SRC     = 8,
    parameter logic [N_SRC-1:0] EDGE_MASK = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_i,
    output logic             irq_req_o,
    output logic [4:0]       irq_id_o,
    input  logic             irq_ack_i,
    input  logic             irq_complete_i,
    input  logic             cfg_we_i,
    input  logic [2:0]       cfg_addr_i,
    input  logic [31:0]      cfg_wdata_i,
    output logic [31:0]      cfg_rdata_o
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SVC
    } state_e;

    localparam int NV = N_SRC + 1;
`ifdef IRQ_CTRL_TIMER_EN
    localparam logic [NV-1:0] EN_MASK = '1;
`else
    localparam logic [NV-1:0] EN_MASK = {1'b0, {N_SRC{1'b1}}};
`endif

    logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [NV-1:0]    en_q, en_d;
    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [4:0]       id_q, id_d;
    logic             tmr_pend;
    logic [NV-1:0]    pend_all, elig;
    logic [31:0]      elig_ext;
    logic [4:0]       win_id;
    logic             ack_take;
    logic             wr_en, wr_pend;

    assign wr_en   = cfg_we_i && (cfg_addr_i == 3'd0);
    assign wr_pend = cfg_we_i && (cfg_addr_i == 3'd1);

`ifdef IRQ_CTRL_TIMER_EN
    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtcmp_q, mtcmp_d;

    // A software write to MTIME replaces that cycle's increment.
    always_comb begin
        mtime_d = mtime_q + 32'd1;
        mtcmp_d = mtcmp_q;
        if (cfg_we_i && cfg_addr_i == 3'd4) mtime_d = cfg_wdata_i;
        if (cfg_we_i && cfg_addr_i == 3'd3) mtcmp_d = cfg_wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q <= 32'd0;
            mtcmp_q <= 32'hFFFF_FFFF;
        end else begin
            mtime_q <= mtime_d;
            mtcmp_q <= mtcmp_d;
        end
    end

    assign tmr_pend = (mtime_q >= mtcmp_q);
`else
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata_i;
    assign tmr_pend     = 1'b0;
`endif

    assign pend_all = {tmr_pend, pend_q};
    assign elig     = pend_all & en_q;
    assign elig_ext = 32'(elig);

    // Lowest id wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_id = 5'd0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (elig[i]) win_id = 5'(i);
        end
    end

    // Edge bits: a new edge beats a same-cycle clear from ack or W1C.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_MASK[i]) begin
                if (wr_pend && cfg_wdata_i[i]) pend_d[i] = 1'b0;
                if (ack_take && id_q == 5'(i)) pend_d[i] = 1'b0;
                if (sync2_q[i] && !sync3_q[i]) pend_d[i] = 1'b1;
            end else begin
                pend_d[i] = sync2_q[i];
            end
        end
    end

    assign en_d = wr_en ? (cfg_wdata_i[NV-1:0] & EN_MASK) : en_q;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        id_d     = id_q;
        ack_take = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    id_d    = win_id;
                end
            end
            S_REQ: begin
                // Ack takes precedence over a same-cycle cancel.
                if (irq_ack_i) begin
                    state_d  = S_SVC;
                    req_d    = 1'b0;
                    ack_take = 1'b1;
                end else if (!elig_ext[id_q]) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            S_SVC: begin
                if (irq_complete_i) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            id_q    <= 5'd0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            en_q    <= en_d;
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        cfg_rdata_o = 32'd0;
        unique case (cfg_addr_i)
            3'd0: cfg_rdata_o = 32'(en_q);
            3'd1: cfg_rdata_o = 32'(pend_all);
            3'd2: cfg_rdata_o = {state_q != S_IDLE, 26'd0, id_q};
`ifdef IRQ_CTRL_TIMER_EN
            3'd3: cfg_rdata_o = mtcmp_q;
            3'd4: cfg_rdata_o = mtime_q;
`endif
            default: cfg_rdata_o = 32'd0;
        endcase
    end

    assign irq_req_o = req_q;
    assign irq_id_o  = id_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: randomized and directed stimulus against a
// behavioural model; request/drop events are checked from a scoreboard.
module tb_irq_controller;
    localparam int NS = 8;
    localparam logic [NS-1:0] EMASK = 8'h27;
`ifdef IRQ_CTRL_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] src = '0;
    logic          irq_req;
    logic [4:0]    irq_id;
    logic          irq_ack = 1'b0;
    logic          irq_complete = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = 3'd0;
    logic [31:0]   cfg_wdata = 32'd0;
    logic [31:0]   cfg_rdata;

    irq_controller #(.N_SRC(NS), .EDGE_MASK(EMASK)) dut (
        .clk_i(clk), .rst_i(rst), .src_i(src),
        .irq_req_o(irq_req), .irq_id_o(irq_id),
        .irq_ack_i(irq_ack), .irq_complete_i(irq_complete),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit req;
        int id;
    } ev_t;

    ev_t expq[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  p = 0;
    int  n = 0;

    // Behavioural model: interrupt state as the software-visible rules
    bit [NS:0]   m_en;
    bit [NS-1:0] m_pend;
    int          m_mode;
    int          m_id;
    bit          m_req;
    bit [31:0]   m_mt, m_cmp;
    bit [NS-1:0] seen [1:3];   // src sampled 1, 2 and 3 edges ago
    bit [NS-1:0] src_v;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_mode = M_IDLE; m_id = 0; m_req = 0;
        m_mt = 32'd0; m_cmp = 32'hFFFF_FFFF;
        for (int k = 1; k <= 3; k++) seen[k] = '0;
    endtask

    function automatic bit m_tpend();
        return TMR && (m_mt >= m_cmp);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return 32'(m_en);
            1: return 32'({m_tpend(), m_pend});
            2: return {m_mode != M_IDLE, 26'd0, 5'(m_id)};
            3: return TMR ? m_cmp : 32'd0;
            4: return TMR ? m_mt : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit [NS-1:0] s, input bit ack,
                              input bit cmp, input bit we, input int a,
                              input bit [31:0] wd);
        bit [NS:0]   el;
        bit [NS-1:0] np;
        bit          prev, acked;
        bit [NS:0]   mask;
        el = {m_tpend(), m_pend} & m_en;
        prev = m_req;
        acked = 0;
        case (m_mode)
            M_IDLE: if (el != 0) begin
                for (int i = 0; i <= NS; i++)
                    if (el[i]) begin m_id = i; break; end
                m_mode = M_REQ; m_req = 1;
            end
            M_REQ: if (ack) begin
                m_mode = M_SVC; m_req = 0; acked = 1;
            end else if (!el[m_id]) begin
                m_mode = M_IDLE; m_req = 0;
            end
            default: if (cmp) m_mode = M_IDLE;
        endcase
        for (int i = 0; i < NS; i++) begin
            if (EMASK[i]) begin
                np[i] = m_pend[i];
                if (we && a == 1 && wd[i]) np[i] = 0;
                if (acked && m_id == i) np[i] = 0;
                if (seen[2][i] && !seen[3][i]) np[i] = 1;
            end else begin
                np[i] = seen[2][i];
            end
        end
        m_pend = np;
        seen[3] = seen[2]; seen[2] = seen[1]; seen[1] = s;
        mask = {TMR, {NS{1'b1}}};
        if (we && a == 0) m_en = wd[NS:0] & mask;
        if (we && a == 3) m_cmp = wd;
        m_mt = (we && a == 4) ? wd : m_mt + 32'd1;
        if (m_req != prev) expq.push_back('{p, m_req, m_id});
    endtask

    task automatic step(input bit [NS-1:0] s, input bit ack, input bit cmp,
                        input bit we, input int a, input bit [31:0] wd);
        src = s; irq_ack = ack; irq_complete = cmp;
        cfg_we = we; cfg_addr = 3'(a); cfg_wdata = wd;
        #1;
        chk($sformatf("rdata[%0d] cyc %0d", a, p), cfg_rdata, m_read(a));
        @(posedge clk);
        p++;
        model_step(s, ack, cmp, we, a, wd);
        #1;
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++)
            step(src_v, 0, 0, 0, $urandom_range(0, 4), 0);
    endtask

    task automatic mid_reset();
        src = '0; src_v = '0; irq_ack = 0; irq_complete = 0; cfg_we = 0;
        #2;
        rst = 1'b1;
        if (m_req) expq.push_back('{p, 1'b0, 0});
        model_reset();
        #1;
        chk("reset irq_req", 32'(irq_req), 32'd0);
        chk("reset irq_id", 32'(irq_id), 32'd0);
        cfg_addr = 3'd0; #1;
        chk("reset ENABLE", cfg_rdata, 32'd0);
        cfg_addr = 3'd1; #1;
        chk("reset PENDING", cfg_rdata, 32'd0);
        cfg_addr = 3'd3; #1;
        chk("reset MTIMECMP", cfg_rdata, TMR ? 32'hFFFF_FFFF : 32'd0);
        @(posedge clk);
        p++;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every change of irq_req must match the next expected event
    bit prev_req = 1'b0;
    always @(negedge clk) begin : mon
        ev_t e;
        n++;
        if (irq_req !== prev_req) begin
            prev_req = irq_req;
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected irq_req=%b id=%0d cyc %0d",
                         irq_req, irq_id, n);
            end else begin
                e = expq.pop_front();
                if (e.cyc != n || e.req !== irq_req || e.id != int'(irq_id)) begin
                    miscompares++;
                    $display("FAIL req event: got req=%b id=%0d cyc %0d expected req=%b id=%0d cyc %0d",
                             irq_req, irq_id, n, e.req, e.id, e.cyc);
                end
            end
        end
    end

    initial begin
        bit ack, cmp, we;
        int a;
        bit [31:0] wd;
        bit [NS-1:0] flip;
        model_reset();
        src_v = '0;
        @(posedge clk); p++;
        @(posedge clk); p++;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) step(src_v, 0, 0, 0, k, 0);

        // basic edge on source 2
        step(src_v, 0, 0, 1, 0, 32'h0F);
        src_v[2] = 1; step(src_v, 0, 0, 0, 1, 0);
        src_v[2] = 0; idle(3);
        step(src_v, 0, 0, 0, 2, 0);
        step(src_v, 1, 0, 0, 1, 0);
        step(src_v, 0, 0, 0, 1, 0);
        step(src_v, 0, 1, 0, 2, 0);
        idle(3);

        // priority and locking
        step(src_v, 0, 0, 1, 0, 32'hFF);
        src_v[5] = 1; idle(4);
        step(src_v, 0, 0, 0, 2, 0);
        src_v[1] = 1; idle(4);
        step(src_v, 1, 0, 0, 2, 0);
        src_v[5] = 0; src_v[1] = 0; idle(3);
        step(src_v, 0, 1, 0, 2, 0);
        idle(4);
        step(src_v, 1, 0, 0, 2, 0);
        step(src_v, 0, 1, 0, 2, 0);

        // level cancel on source 3, then a late ack
        step(src_v, 0, 0, 1, 0, 32'h08);
        src_v[3] = 1; idle(5);
        src_v[3] = 0; idle(4);
        step(src_v, 1, 0, 0, 2, 0);
        idle(2);

        // ack together with ENABLE clearing the locked id, no nesting
        step(src_v, 0, 0, 1, 0, 32'h10);
        src_v[4] = 1; idle(5);
        step(src_v, 1, 0, 1, 0, 32'h01);
        src_v[4] = 0; src_v[0] = 1; step(src_v, 0, 0, 0, 1, 0);
        src_v[0] = 0; idle(6);
        step(src_v, 0, 1, 0, 2, 0);
        idle(4);
        step(src_v, 1, 0, 0, 2, 0);
        step(src_v, 0, 1, 0, 2, 0);

        // timer wrap, or its absence
        step(src_v, 0, 0, 1, 4, 32'hFFFF_FFFE);
        step(src_v, 0, 0, 1, 3, 32'h1);
        step(src_v, 0, 0, 1, 0, 32'h100);
        idle(2);
        step(src_v, 0, 0, 0, 4, 0);
        step(src_v, 0, 0, 0, 2, 0);
        step(src_v, 1, 0, 1, 0, 32'h0);
        step(src_v, 0, 0, 1, 3, 32'hFFFF_FFFF);
        step(src_v, 0, 1, 0, 4, 0);
        idle(3);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            flip = '0;
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 9) == 0) flip[i] = 1;
            src_v ^= flip;
            ack = (m_mode == M_REQ) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 15) == 0);
            cmp = (m_mode == M_SVC) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 15) == 0);
            we = ($urandom_range(0, 7) == 0);
            wd = $urandom;
            if (we) begin
                a = $urandom_range(0, 5);
                if (a >= 3) a = a + 2;
                if (a == 0) wd = wd & 32'hFF;
            end else begin
                a = $urandom_range(0, 7);
            end
            step(src_v, ack, cmp, we, a, wd);
        end

        // reset while a request is up
        src_v = '0;
        idle(4);
        step(src_v, 1, 0, 0, 2, 0);
        step(src_v, 0, 1, 1, 0, 32'hFF);
        src_v[6] = 1; idle(5);
        mid_reset();
        idle(6);

        chk("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
